// File: rtl/cereal_pkg.sv
// rtl/cereal_pkg.sv - shared definitions for the cereal serial link (receiver FSM states, default bit timing)
package cereal_pkg;

  // 50 MHz sysclk / 9600 baud; the transmitter uses the same constant so both ends stay matched.
  localparam int CEREAL_CLKS_PER_BIT = 5208;
  localparam int CEREAL_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for a single asynchronous input with a selectable reset value
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/cereal_rx.sv
// rtl/cereal_rx.sv - serial frame receiver: start/data/stop recovery by bit-centre sampling,
// parallel byte out with one-cycle valid or frame_err strobes
module cereal_rx
  import cereal_pkg::*;
#(
  parameter int CLKS_PER_BIT = CEREAL_CLKS_PER_BIT,
  parameter int DATA_BITS    = CEREAL_DATA_BITS
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 cereal_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic rx_s;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (sysclk),
    .reset (reset),
    .d     (cereal_in),
    .q     (rx_s)
  );

  rx_state_e            state_q,     state_d;
  logic [CW-1:0]        clk_cnt_q,   clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q,   bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] data_q,      data_d;
  logic                 valid_q,     valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q,      busy_d;

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d   = S_START;
          clk_cnt_d = '0;
        end
      end

      // A start bit that is high again at its centre was a glitch: drop it silently.
      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          if (!rx_s) begin
            state_d   = S_DATA;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          clk_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = S_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      // A held-low line must return high before a new start edge can be recognised.
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cereal_rx.sv
// tb/tb_cereal_rx.sv - self-checking bench for cereal_rx: frame table, corner sequences, random frames
module tb_cereal_rx;

  localparam int CPB = 16;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       cereal_in;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  int  ev_q[$];
  int  exp_ev[$];
  bit  prev_pulse = 1'b0;
  logic [7:0] last_good;

  always #5 sysclk = ~sysclk;

  cereal_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .cereal_in (cereal_in),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observed strobes become events: 0x1xx = good byte xx, 0x200 = framing error.
  always @(negedge sysclk) begin
    if (valid || frame_err) begin
      check("valid_and_ferr_exclusive", {31'd0, valid && frame_err}, 32'd0);
      check("strobe_single_cycle", {31'd0, prev_pulse}, 32'd0);
      if (valid)     ev_q.push_back(32'h100 | {24'd0, data_out});
      if (frame_err) ev_q.push_back(32'h200);
    end
    prev_pulse = valid || frame_err;
  end

  task automatic check_events(input string name);
    int n;
    check({name, "_event_count"}, ev_q.size(), exp_ev.size());
    n = (ev_q.size() < exp_ev.size()) ? ev_q.size() : exp_ev.size();
    for (int i = 0; i < n; i++) check({name, "_event"}, ev_q[i], exp_ev[i]);
    ev_q.delete();
    exp_ev.delete();
  endtask

  task automatic drive_bit(input logic v, input int cycles);
    cereal_in = v;
    repeat (cycles) @(posedge sysclk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input bit stop_ok, input int gap_bits);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (stop_ok) drive_bit(1'b1, p);
    else         drive_bit(1'b0, 40);
    if (gap_bits > 0) drive_bit(1'b1, gap_bits * p);
  endtask

  typedef struct {
    logic [7:0] data;
    int         period;
    bit         stop_ok;
    int         gap_bits;
    int         exp_event;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{8'hA5, 16, 1'b1, 2, 32'h1A5, 8'hA5};
    tbl[1] = '{8'h00, 16, 1'b1, 0, 32'h100, 8'h00};
    tbl[2] = '{8'hFF, 16, 1'b1, 0, 32'h1FF, 8'hFF};
    tbl[3] = '{8'h55, 16, 1'b1, 0, 32'h155, 8'h55};
    tbl[4] = '{8'h3C, 16, 1'b1, 2, 32'h13C, 8'h3C};
    tbl[5] = '{8'hC3, 15, 1'b1, 2, 32'h1C3, 8'hC3};
    tbl[6] = '{8'hC3, 17, 1'b1, 2, 32'h1C3, 8'hC3};
    tbl[7] = '{8'h81, 16, 1'b0, 3, 32'h200, 8'hC3};
    tbl[8] = '{8'h5A, 16, 1'b1, 2, 32'h15A, 8'h5A};

    reset     = 1'b1;
    cereal_in = 1'b1;
    repeat (4) @(posedge sysclk);
    #1 reset = 1'b0;
    @(negedge sysclk);
    check("reset_data_out", {24'd0, data_out}, 32'h00);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge sysclk);
    #1;
    drive_bit(1'b1, 2 * CPB);

    for (int i = 0; i < 9; i++) begin
      exp_ev.push_back(tbl[i].exp_event);
      send_frame(tbl[i].data, tbl[i].period, tbl[i].stop_ok, tbl[i].gap_bits);
      if (tbl[i].gap_bits > 0) begin
        check_events($sformatf("tbl%0d", i));
        check($sformatf("tbl%0d_data_out", i), {24'd0, data_out}, {24'd0, tbl[i].exp_dout});
        check($sformatf("tbl%0d_busy_idle", i), {31'd0, busy}, 32'd0);
      end
    end
    last_good = 8'h5A;

    // Short low glitch on an idle line.
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 3 * CPB);
    check_events("glitch");
    check("glitch_data_out", {24'd0, data_out}, {24'd0, last_good});
    check("glitch_busy", {31'd0, busy}, 32'd0);

    // Random frames at nominal timing against a byte-level event model.
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      bit ok;
      int gap;
      d   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 7) != 0);
      gap = ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
      if (ok) begin
        exp_ev.push_back(32'h100 | {24'd0, d});
        last_good = d;
      end else begin
        exp_ev.push_back(32'h200);
      end
      send_frame(d, CPB, ok, gap);
      if (gap > 0) begin
        check_events($sformatf("rand%0d", k));
        check($sformatf("rand%0d_data_out", k), {24'd0, data_out}, {24'd0, last_good});
      end
    end
    drive_bit(1'b1, 2 * CPB);
    check_events("rand_tail");
    check("rand_tail_data_out", {24'd0, data_out}, {24'd0, last_good});

    // Reset pulse in the middle of data bit 3 of frame 0x42.
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(logic'((8'h42 >> i) & 8'h01), CPB);
    cereal_in = 1'b0;
    repeat (7) @(posedge sysclk);
    #1 reset = 1'b1;
    @(posedge sysclk);
    #1 reset = 1'b0;
    @(negedge sysclk);
    check("midreset_data_out", {24'd0, data_out}, 32'h00);
    check("midreset_valid", {31'd0, valid}, 32'd0);
    check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    @(posedge sysclk);
    #1;
    drive_bit(1'b0, CPB - 9);
    for (int i = 4; i < 8; i++) drive_bit(logic'((8'h42 >> i) & 8'h01), CPB);
    drive_bit(1'b1, 12 * CPB);
    ev_q.delete();
    exp_ev.delete();

    exp_ev.push_back(32'h117);
    send_frame(8'h17, CPB, 1'b1, 2);
    check_events("after_reset");
    check("after_reset_data_out", {24'd0, data_out}, 32'h17);
    check("after_reset_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
